// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter and the line
// conditioning it shares with the PS/2 receivers.
package ps2_host_tx_pkg;

    // Transmitter sequencing states
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        INHIBIT    = 3'd1,
        START      = 3'd2,
        WAIT_FIRST = 3'd3,
        SEND       = 3'd4,
        RELEASE    = 3'd5
    } tx_state_e;

    // Frame layout: 8 data bits LSB first, odd parity, stop, device ACK.
    localparam int unsigned DATA_BITS   = 32'd8;
    localparam int unsigned FRAME_BITS  = 32'd10;  // data + parity + stop
    localparam int unsigned PARITY_EDGE = 32'd9;
    localparam int unsigned STOP_EDGE   = 32'd10;
    localparam int unsigned ACK_EDGE    = 32'd11;

    // Default timing at a 50 MHz system clock
    localparam int unsigned DEF_CLK_HZ       = 32'd50_000_000;
    localparam int unsigned DEF_INHIBIT_CYC  = 32'd6_000;     // 120 us
    localparam int unsigned DEF_START_CYC    = 32'd100;       // 2 us
    localparam int unsigned DEF_FIRST_TO_CYC = 32'd750_000;   // 15 ms
    localparam int unsigned DEF_PKT_TO_CYC   = 32'd100_000;   // 2 ms
    localparam int unsigned DEF_FILT_LEN     = 32'd4;

    // Odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [DATA_BITS-1:0] data);
        return ~(^data);
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Conditions one raw PS/2 pin: two-flop synchronizer, FILT_LEN-sample
// agreement filter, and a one-cycle pulse on each filtered falling edge.
// The idle (released) bus level is high, so everything resets to 1.
module ps2_line_sync #(
    parameter int unsigned FILT_LEN = 32'd4
) (
    input  logic CLOCK,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic fall
);

    logic                sync1_r;
    logic                sync2_r;
    logic [FILT_LEN-1:0] hist_r;
    logic                level_r;
    logic                fall_r;

    // Synchronize the pin, keep a short history and accept a change only
    // once every sample in the history agrees on the new level.
    always_ff @(posedge CLOCK) begin
        if (reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            hist_r  <= {FILT_LEN{1'b1}};
            level_r <= 1'b1;
            fall_r  <= 1'b0;
        end else begin
            sync1_r <= pin;
            sync2_r <= sync1_r;
            hist_r  <= {hist_r[FILT_LEN-2:0], sync2_r};
            if ((&hist_r) && !level_r) begin
                level_r <= 1'b1;
                fall_r  <= 1'b0;
            end else if ((~|hist_r) && level_r) begin
                level_r <= 1'b0;
                fall_r  <= 1'b1;
            end else begin
                fall_r  <= 1'b0;
            end
        end
    end

    assign level = level_r;
    assign fall  = fall_r;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Inhibits the bus, issues the start
// condition, then shifts data/parity/stop on device-generated falling clock
// edges and collects the device ACK. The *_oe outputs drive open-collector
// pads (1 = pull low); busy tells the companion receiver to ignore the bus.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int unsigned CLK_HZ       = DEF_CLK_HZ,
    parameter int unsigned INHIBIT_CYC  = DEF_INHIBIT_CYC,
    parameter int unsigned START_CYC    = DEF_START_CYC,
    parameter int unsigned FIRST_TO_CYC = DEF_FIRST_TO_CYC,
    parameter int unsigned PKT_TO_CYC   = DEF_PKT_TO_CYC,
    parameter int unsigned FILT_LEN     = DEF_FILT_LEN
) (
    input  logic                 CLOCK,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic                 ps2ck_in,
    input  logic                 ps2dt_in,
    output logic                 ck_oe,
    output logic                 dt_oe,
    output logic                 busy,
    output logic                 done,
    output logic                 ack_ok,
    output logic                 err_timeout
);

    // All timing is expressed directly in cycles; the clock rate is kept for
    // documentation and for callers deriving the cycle counts.
    localparam int unsigned clk_hz_unused = CLK_HZ;

    // One timer serves every phase, so size it for the longest one.
    localparam int unsigned TO_MAX  = (FIRST_TO_CYC > PKT_TO_CYC) ? FIRST_TO_CYC : PKT_TO_CYC;
    localparam int unsigned PH_MAX  = (INHIBIT_CYC > START_CYC) ? INHIBIT_CYC : START_CYC;
    localparam int unsigned T_MAX   = (TO_MAX > PH_MAX) ? TO_MAX : PH_MAX;
    localparam int unsigned TW      = $clog2(T_MAX + 32'd1);

    localparam logic [TW-1:0] INHIBIT_LAST = TW'(INHIBIT_CYC - 32'd1);
    localparam logic [TW-1:0] START_LAST   = TW'(START_CYC - 32'd1);
    localparam logic [TW-1:0] FIRST_LAST   = TW'(FIRST_TO_CYC - 32'd1);
    localparam logic [TW-1:0] PKT_LAST     = TW'(PKT_TO_CYC - 32'd1);
    localparam logic [TW-1:0] TIMER_SAT    = {TW{1'b1}};
    localparam logic [TW-1:0] TIMER_ONE    = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [3:0]    ACK_EDGE_4   = 4'(ACK_EDGE);

    // Conditioned bus lines
    logic ck_level_s;
    logic ck_fall_s;
    logic dt_level_s;
    logic dt_fall_unused_s;

    ps2_line_sync #(.FILT_LEN(FILT_LEN)) u_ck_sync (
        .CLOCK (CLOCK),
        .reset (reset),
        .pin   (ps2ck_in),
        .level (ck_level_s),
        .fall  (ck_fall_s)
    );

    ps2_line_sync #(.FILT_LEN(FILT_LEN)) u_dt_sync (
        .CLOCK (CLOCK),
        .reset (reset),
        .pin   (ps2dt_in),
        .level (dt_level_s),
        .fall  (dt_fall_unused_s)
    );

    // Sequencer state and registered outputs
    tx_state_e             state_r;
    logic [FRAME_BITS-1:0] shift_r;      // {stop, parity, data[7:0]}
    logic [3:0]            edge_cnt_r;
    logic [TW-1:0]         timer_r;
    logic                  ck_oe_r;
    logic                  dt_oe_r;
    logic                  tx_ready_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  ack_ok_r;
    logic                  ack_pend_r;   // ACK captured at the last edge
    logic                  err_timeout_r;

    logic [TW-1:0] timer_inc_s;
    logic [3:0]    edge_inc_s;
    logic          pkt_expired_s;

    // The timer holds at its maximum rather than wrapping back to zero.
    assign timer_inc_s   = (timer_r == TIMER_SAT) ? timer_r : (timer_r + TIMER_ONE);
    assign edge_inc_s    = edge_cnt_r + 4'd1;
    assign pkt_expired_s = (timer_r == PKT_LAST);

    // Transmit sequencer. Timeouts are tested before clock edges so that a
    // coincident expiry and edge always resolve as a timeout.
    always_ff @(posedge CLOCK) begin
        if (reset) begin
            state_r       <= IDLE;
            shift_r       <= {FRAME_BITS{1'b0}};
            edge_cnt_r    <= 4'd0;
            timer_r       <= {TW{1'b0}};
            ck_oe_r       <= 1'b0;
            dt_oe_r       <= 1'b0;
            tx_ready_r    <= 1'b1;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            ack_ok_r      <= 1'b0;
            ack_pend_r    <= 1'b0;
            err_timeout_r <= 1'b0;
        end else begin
            done_r        <= 1'b0;
            ack_ok_r      <= 1'b0;
            err_timeout_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (tx_valid) begin
                        shift_r    <= {1'b1, odd_parity(tx_data), tx_data};
                        edge_cnt_r <= 4'd0;
                        timer_r    <= {TW{1'b0}};
                        ck_oe_r    <= 1'b1;
                        dt_oe_r    <= 1'b0;
                        tx_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (timer_r == INHIBIT_LAST) begin
                        timer_r <= {TW{1'b0}};
                        dt_oe_r <= 1'b1;          // start bit
                        state_r <= START;
                    end else begin
                        timer_r <= timer_inc_s;
                    end
                end
                START: begin
                    if (timer_r == START_LAST) begin
                        timer_r <= {TW{1'b0}};
                        ck_oe_r <= 1'b0;          // hand the clock to the device
                        state_r <= WAIT_FIRST;
                    end else begin
                        timer_r <= timer_inc_s;
                    end
                end
                WAIT_FIRST: begin
                    if (timer_r == FIRST_LAST) begin
                        ck_oe_r       <= 1'b0;
                        dt_oe_r       <= 1'b0;
                        err_timeout_r <= 1'b1;
                        tx_ready_r    <= 1'b1;
                        busy_r        <= 1'b0;
                        state_r       <= IDLE;
                    end else if (ck_fall_s) begin
                        edge_cnt_r <= 4'd1;
                        dt_oe_r    <= ~shift_r[0];
                        timer_r    <= {TW{1'b0}};  // packet budget starts here
                        state_r    <= SEND;
                    end else begin
                        timer_r <= timer_inc_s;
                    end
                end
                SEND: begin
                    if (pkt_expired_s) begin
                        ck_oe_r       <= 1'b0;
                        dt_oe_r       <= 1'b0;
                        err_timeout_r <= 1'b1;
                        tx_ready_r    <= 1'b1;
                        busy_r        <= 1'b0;
                        state_r       <= IDLE;
                    end else begin
                        timer_r <= timer_inc_s;
                        if (ck_fall_s) begin
                            edge_cnt_r <= edge_inc_s;
                            if (edge_inc_s == ACK_EDGE_4) begin
                                ack_pend_r <= ~dt_level_s;
                                dt_oe_r    <= 1'b0;
                                state_r    <= RELEASE;
                            end else begin
                                // Edge n drives frame bit n-1: data, parity,
                                // then the stop bit, which releases the line.
                                dt_oe_r <= ~shift_r[edge_cnt_r];
                            end
                        end
                    end
                end
                RELEASE: begin
                    if (pkt_expired_s) begin
                        ck_oe_r       <= 1'b0;
                        dt_oe_r       <= 1'b0;
                        err_timeout_r <= 1'b1;
                        tx_ready_r    <= 1'b1;
                        busy_r        <= 1'b0;
                        state_r       <= IDLE;
                    end else if (ck_level_s && dt_level_s) begin
                        done_r     <= 1'b1;
                        ack_ok_r   <= ack_pend_r;
                        tx_ready_r <= 1'b1;
                        busy_r     <= 1'b0;
                        state_r    <= IDLE;
                    end else begin
                        timer_r <= timer_inc_s;
                    end
                end
                default: begin
                    ck_oe_r    <= 1'b0;
                    dt_oe_r    <= 1'b0;
                    tx_ready_r <= 1'b1;
                    busy_r     <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

    assign tx_ready    = tx_ready_r;
    assign ck_oe       = ck_oe_r;
    assign dt_oe       = dt_oe_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign ack_ok      = ack_ok_r;
    assign err_timeout = err_timeout_r;

endmodule
